// File: rtl/vid_pkg.sv
// Shared encodings for the frame-buffer burst scheduler: source tags, FSM states
// and default burst lengths.
package vid_pkg;

    localparam logic [1:0] SRC_WR  = 2'd0;
    localparam logic [1:0] SRC_RD0 = 2'd1;
    localparam logic [1:0] SRC_RD1 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } burstState_e;

    localparam int DEF_WR_LEN = 160;
    localparam int DEF_RD_LEN = 160;

    // Round-robin successor over the three sources (wr -> rd0 -> rd1 -> wr).
    function automatic logic [1:0] nextSrc(input logic [1:0] src);
        return (src >= SRC_RD1) ? SRC_WR : src + 2'd1;
    endfunction

endpackage

// File: rtl/vid_rr_pick3.sv
// Combinational 3-way round-robin selector: first pending source at or after ptr.
module vid_rr_pick3
    import vid_pkg::*;
(
    input  logic [2:0] pend,
    input  logic [1:0] ptr,
    output logic [1:0] sel,
    output logic       any
);

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    always_comb begin
        cand0 = (ptr > SRC_RD1) ? SRC_WR : ptr;
        cand1 = nextSrc(cand0);
        cand2 = nextSrc(cand1);
        any   = |pend;
        if (pend[cand0])
            sel = cand0;
        else if (pend[cand1])
            sel = cand1;
        else if (pend[cand2])
            sel = cand2;
        else
            sel = SRC_WR;
    end

endmodule

// File: rtl/vid_fb_burst_scheduler.sv
// Arbitrates the single PSRAM burst command port between the GB line writer and the
// blend/OSD line readers, one burst at a time, with done pulses and a stuck-burst timeout.
module vid_fb_burst_scheduler
    import vid_pkg::*;
#(
    parameter int ADDR_W  = 23,
    parameter int LEN_W   = 9,
    parameter int WR_LEN  = DEF_WR_LEN,
    parameter int RD_LEN  = DEF_RD_LEN,
    parameter int TIMEOUT = 4095
) (
    input  logic              hClk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic              rd1_en,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic [1:0]        cmd_src,
    input  logic              mem_done,
    output logic              done_wr,
    output logic              done_rd0,
    output logic              done_rd1,
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output logic              timeout_flag
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    burstState_e       state;
    logic [2:0]        pend;
    logic [2:0]        pendNext;
    logic [2:0]        pendEff;
    logic [2:0]        reqHit;
    logic [2:0]        reqOk;
    logic [2:0]        reqOvr;
    logic [2:0]        inFlight;
    logic [1:0]        ovrInc;
    logic [1:0]        rrPtr;
    logic [1:0]        pickSel;
    logic              pickAny;
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] addrIn  [3];
    logic [ADDR_W-1:0] srcAddr [3];

    function automatic logic [7:0] satAdd(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    always_comb begin
        addrIn[0] = wr_addr;
        addrIn[1] = rd0_addr;
        addrIn[2] = rd1_addr;

        // busy implies cmd_src names the burst currently owned by the controller
        inFlight = 3'b000;
        if (busy)
            inFlight[cmd_src] = 1'b1;

        reqHit = {rd1_req & rd1_en, rd0_req, wr_req};
        reqOvr = reqHit & (pend | inFlight);
        reqOk  = reqHit & ~(pend | inFlight);
        ovrInc = 2'(reqOvr[0]) + 2'(reqOvr[1]) + 2'(reqOvr[2]);

        // Reads being flushed this cycle must not win the grant
        pendEff = pend & {rd1_en & ~frame_start, ~frame_start, 1'b1};

        pendNext = pend;
        if (state == ST_IDLE && pickAny)
            pendNext[pickSel] = 1'b0;
        if (frame_start)
            pendNext[2:1] = 2'b00;
        if (!rd1_en)
            pendNext[2] = 1'b0;
        pendNext = pendNext | reqOk;
    end

    vid_rr_pick3 uPick (
        .pend (pendEff),
        .ptr  (rrPtr),
        .sel  (pickSel),
        .any  (pickAny)
    );

    always_ff @(posedge hClk) begin
        for (int s = 0; s < 3; s++)
            if (reqOk[s])
                srcAddr[s] <= addrIn[s];
    end

    always_ff @(posedge hClk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pend         <= 3'b000;
            rrPtr        <= SRC_WR;
            timer        <= '0;
            cmd_valid    <= 1'b0;
            cmd_write    <= 1'b0;
            cmd_addr     <= '0;
            cmd_len      <= '0;
            cmd_src      <= SRC_WR;
            done_wr      <= 1'b0;
            done_rd0     <= 1'b0;
            done_rd1     <= 1'b0;
            busy         <= 1'b0;
            overrun_cnt  <= 8'd0;
            timeout_flag <= 1'b0;
        end else begin
            pend        <= pendNext;
            overrun_cnt <= satAdd(overrun_cnt, ovrInc);
            done_wr     <= 1'b0;
            done_rd0    <= 1'b0;
            done_rd1    <= 1'b0;
            if (frame_start)
                timeout_flag <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pickAny) begin
                        cmd_valid <= 1'b1;
                        cmd_src   <= pickSel;
                        cmd_write <= (pickSel == SRC_WR);
                        cmd_addr  <= srcAddr[pickSel];
                        cmd_len   <= (pickSel == SRC_WR) ? LEN_W'(WR_LEN) : LEN_W'(RD_LEN);
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        timer     <= TMR_W'(TIMEOUT);
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A timed-out burst is abandoned but still reported as done
                    if (mem_done || timer == '0) begin
                        if (!mem_done)
                            timeout_flag <= 1'b1;
                        case (cmd_src)
                            SRC_WR:  done_wr  <= 1'b1;
                            SRC_RD0: done_rd0 <= 1'b1;
                            default: done_rd1 <= 1'b1;
                        endcase
                        rrPtr <= nextSrc(cmd_src);
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vid_fb_burst_scheduler.sv
// Scoreboard bench: expected bursts are queued at request time and checked on accept/done.
module tb_vid_fb_burst_scheduler;

    typedef struct packed {
        logic        write;
        logic [22:0] addr;
        logic [8:0]  len;
        logic [1:0]  src;
    } cmdExp_t;

    logic        hClk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        wr_req = 1'b0;
    logic [22:0] wr_addr = '0;
    logic        rd0_req = 1'b0;
    logic [22:0] rd0_addr = '0;
    logic        rd1_req = 1'b0;
    logic [22:0] rd1_addr = '0;
    logic        rd1_en = 1'b1;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic        cmd_write;
    logic [22:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic [1:0]  cmd_src;
    logic        mem_done = 1'b0;
    logic        done_wr;
    logic        done_rd0;
    logic        done_rd1;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic        timeout_flag;

    cmdExp_t    expQ[$];
    logic [1:0] flightQ[$];
    int         nChecks = 0;
    int         nErrors = 0;
    int         nCmd = 0;
    int         nDone = 0;
    int         nDoneRd1 = 0;
    int         memDelay = 0;
    int         memCnt = 0;

    vid_fb_burst_scheduler dut (
        .hClk         (hClk),
        .reset        (reset),
        .frame_start  (frame_start),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .rd0_req      (rd0_req),
        .rd0_addr     (rd0_addr),
        .rd1_req      (rd1_req),
        .rd1_addr     (rd1_addr),
        .rd1_en       (rd1_en),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_src      (cmd_src),
        .mem_done     (mem_done),
        .done_wr      (done_wr),
        .done_rd0     (done_rd0),
        .done_rd1     (done_rd1),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .timeout_flag (timeout_flag)
    );

    initial forever #5 hClk = ~hClk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic cmdExp_t mkExp(input logic [1:0] src, input logic [22:0] addr);
        cmdExp_t e;
        e.write = (src == 2'd0);
        e.addr  = addr;
        e.len   = 9'd160;
        e.src   = src;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge hClk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick(2);
        expQ.delete();
        flightQ.delete();
        reset = 1'b0;
        tick(1);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while ((expQ.size() != 0 || flightQ.size() != 0 || busy) && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic waitInWait(input string tag, input int budget);
        int n = 0;
        while (!(busy && !cmd_valid) && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    // Controller model and output monitor, sampled on the falling edge
    always @(negedge hClk) begin
        cmdExp_t    e;
        logic [1:0] s;
        mem_done = 1'b0;
        if (reset) begin
            memCnt = 0;
        end else begin
            if (memCnt > 0) begin
                memCnt--;
                if (memCnt == 0)
                    mem_done = 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_cmd", {30'd0, cmd_src}, 32'hFFFF);
                end else begin
                    e = expQ.pop_front();
                    chk("cmd_src", 32'(cmd_src), 32'(e.src));
                    chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
                    chk("cmd_len", 32'(cmd_len), 32'(e.len));
                    chk("cmd_write", 32'(cmd_write), 32'(e.write));
                end
                flightQ.push_back(cmd_src);
                nCmd++;
                if (memDelay > 0)
                    memCnt = memDelay;
            end
            if (done_wr || done_rd0 || done_rd1) begin
                chk("done_onehot", 32'(done_wr) + 32'(done_rd0) + 32'(done_rd1), 32'd1);
                if (flightQ.size() == 0) begin
                    chk("unexpected_done", {29'd0, done_rd1, done_rd0, done_wr}, 32'd0);
                end else begin
                    s = flightQ.pop_front();
                    chk("done_src", {29'd0, done_rd1, done_rd0, done_wr}, 32'd1 << s);
                end
                nDone++;
                if (done_rd1)
                    nDoneRd1++;
            end
        end
    end

    initial begin
        int         c0;
        int         d0;
        int         k;
        logic [7:0] ovr0;
        logic [22:0] holdAddr;
        logic [1:0]  holdSrc;
        logic        stable;

        doReset();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_write", 32'(cmd_write), 32'd0);
        chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst_cmd_len", 32'(cmd_len), 32'd0);
        chk("rst_cmd_src", 32'(cmd_src), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        chk("rst_timeout", 32'(timeout_flag), 32'd0);
        chk("rst_done", {29'd0, done_rd1, done_rd0, done_wr}, 32'd0);

        // Single write burst: two-cycle request-to-command latency
        memDelay = 20;
        d0 = nDone;
        expQ.push_back(mkExp(2'd0, 23'h10000));
        wr_addr = 23'h10000;
        wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0;
        chk("lat_cycle1_valid", 32'(cmd_valid), 32'd0);
        tick(1);
        chk("lat_cycle2_valid", 32'(cmd_valid), 32'd1);
        chk("lat_cycle2_busy", 32'(busy), 32'd1);
        waitIdle("t1_idle", 100);
        chk("t1_done_count", 32'(nDone - d0), 32'd1);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // Three simultaneous requests from a reset pointer: wr, rd0, rd1
        doReset();
        memDelay = 8;
        d0 = nDone;
        expQ.push_back(mkExp(2'd0, 23'h00100));
        expQ.push_back(mkExp(2'd1, 23'h00200));
        expQ.push_back(mkExp(2'd2, 23'h00300));
        wr_addr = 23'h00100; rd0_addr = 23'h00200; rd1_addr = 23'h00300;
        wr_req = 1'b1; rd0_req = 1'b1; rd1_req = 1'b1;
        tick(1);
        wr_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
        waitIdle("t2_idle", 200);
        chk("t2_done_count", 32'(nDone - d0), 32'd3);
        chk("t2_overrun", 32'(overrun_cnt), 32'd0);

        // Two extra rd0 requests while rd0 is in flight are overruns
        memDelay = 30;
        c0 = nCmd;
        expQ.push_back(mkExp(2'd1, 23'h04000));
        rd0_addr = 23'h04000;
        rd0_req = 1'b1;
        tick(1);
        rd0_req = 1'b0;
        waitInWait("t3_reach_wait", 20);
        rd0_addr = 23'h05000; rd0_req = 1'b1;
        tick(1);
        rd0_req = 1'b0;
        tick(1);
        rd0_addr = 23'h06000; rd0_req = 1'b1;
        tick(1);
        rd0_req = 1'b0;
        waitIdle("t3_idle", 200);
        tick(5);
        chk("t3_overrun", 32'(overrun_cnt), 32'd2);
        chk("t3_cmd_count", 32'(nCmd - c0), 32'd1);

        // Pending rd1 flushed by rd1_en low while a write occupies the port
        memDelay = 40;
        c0 = nCmd;
        d0 = nDoneRd1;
        ovr0 = overrun_cnt;
        expQ.push_back(mkExp(2'd0, 23'h02000));
        wr_addr = 23'h02000; wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0;
        waitInWait("t4_reach_wait", 20);
        rd1_addr = 23'h03000; rd1_req = 1'b1;
        tick(1);
        rd1_req = 1'b0;
        tick(2);
        rd1_en = 1'b0;
        tick(1);
        rd1_en = 1'b1;
        waitIdle("t4_idle", 200);
        tick(5);
        chk("t4_cmd_count", 32'(nCmd - c0), 32'd1);
        chk("t4_no_done_rd1", 32'(nDoneRd1 - d0), 32'd0);
        chk("t4_overrun_held", 32'(overrun_cnt), 32'(ovr0));

        // Back-pressure: command held stable for 50 cycles, accepted on first ready
        memDelay = 5;
        cmd_ready = 1'b0;
        expQ.push_back(mkExp(2'd0, 23'h0ABCD));
        wr_addr = 23'h0ABCD; wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0;
        k = 0;
        while (!cmd_valid && k < 10) begin
            tick(1);
            k++;
        end
        chk("t5_valid_seen", 32'(cmd_valid), 32'd1);
        holdAddr = cmd_addr;
        holdSrc = cmd_src;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (!cmd_valid || cmd_addr !== holdAddr || cmd_src !== holdSrc)
                stable = 1'b0;
        end
        chk("t5_stable", 32'(stable), 32'd1);
        chk("t5_hold_addr", 32'(holdAddr), 32'h0ABCD);
        cmd_ready = 1'b1;
        tick(1);
        chk("t5_accept_valid", 32'(cmd_valid), 32'd0);
        chk("t5_accept_busy", 32'(busy), 32'd1);
        waitIdle("t5_idle", 100);

        // Timeout: no mem_done, flag and done pulse 4096 cycles after accept
        memDelay = 0;
        ovr0 = overrun_cnt;
        expQ.push_back(mkExp(2'd1, 23'h07000));
        rd0_addr = 23'h07000; rd0_req = 1'b1;
        tick(1);
        rd0_req = 1'b0;
        waitInWait("t6_reach_wait", 20);
        k = 0;
        while (!timeout_flag && k < 5000) begin
            tick(1);
            k++;
        end
        chk("t6_timeout_latency", 32'(k), 32'd4096);
        chk("t6_timeout_done", 32'(done_rd0), 32'd1);
        tick(1);
        chk("t6_flag_sticky", 32'(timeout_flag), 32'd1);
        chk("t6_busy_low", 32'(busy), 32'd0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("t6_flag_cleared", 32'(timeout_flag), 32'd0);
        chk("t6_overrun_kept", 32'(overrun_cnt), 32'(ovr0));

        // Asynchronous reset while waiting on a burst
        expQ.push_back(mkExp(2'd0, 23'h08000));
        wr_addr = 23'h08000; wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0;
        waitInWait("t7_reach_wait", 20);
        reset = 1'b1;
        #1;
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("t7_cmd_write", 32'(cmd_write), 32'd0);
        chk("t7_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("t7_cmd_len", 32'(cmd_len), 32'd0);
        chk("t7_cmd_src", 32'(cmd_src), 32'd0);
        chk("t7_overrun", 32'(overrun_cnt), 32'd0);
        expQ.delete();
        flightQ.delete();
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("t7_post_valid", 32'(cmd_valid), 32'd0);
        chk("t7_post_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
